// File: rtl/soc_event_tx_pkg.sv
// Shared types and helpers for the SoC-side event token transmitter.
// Default-geometry widths live here; the top re-derives them from its own parameters.
package soc_event_tx_pkg;

    localparam int DEF_BUFFER_WIDTH = 8;
    localparam int DEF_EVNT_WIDTH   = 8;
    localparam int FILL_W           = $clog2(DEF_BUFFER_WIDTH + 1);
    localparam int IDX_W            = $clog2(DEF_BUFFER_WIDTH);

    typedef logic [DEF_EVNT_WIDTH-1:0] evt_t;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/soc_event_rr_arb.sv
// Round-robin arbiter over NB_CH valid bits; pointer advances past the grant on upd_i.
// Grant is combinational from valid_i and the registered pointer.
module soc_event_rr_arb #(
    parameter int NB_CH = 4,
    localparam int CH_W = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NB_CH-1:0] valid_i,
    input  logic             upd_i,
    output logic [CH_W-1:0]  gnt_idx_o,
    output logic [NB_CH-1:0] gnt_oh_o,
    output logic             gnt_vld_o
);

    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] rr_ptr_d;

    always_comb begin
        int c;
        logic found;
        c         = 0;
        found     = 1'b0;
        gnt_idx_o = '0;
        gnt_oh_o  = '0;
        for (int i = 0; i < NB_CH; i++) begin
            c = (int'(rr_ptr_q) + i) % NB_CH;
            if (!found && valid_i[c]) begin
                found     = 1'b1;
                gnt_idx_o = CH_W'(c);
            end
        end
        if (found) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
        gnt_vld_o = found;

        rr_ptr_d = rr_ptr_q;
        if (upd_i) begin
            rr_ptr_d = (int'(gnt_idx_o) == NB_CH - 1) ? '0 : CH_W'(int'(gnt_idx_o) + 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/soc_event_token_tx.sv
// Merges NB_CH event sources into a toggle-token ring shared with the cluster domain.
// Accepted events appear on events_wt_o/events_da_o one edge later; full blocks or drops per BLOCKING.
module soc_event_token_tx
    import soc_event_tx_pkg::*;
#(
    parameter int NB_CH          = 4,
    parameter int BUFFER_WIDTH   = 8,
    parameter int EVNT_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int BLOCKING       = 1,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int FILL_BITS     = $clog2(BUFFER_WIDTH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_CH-1:0]                   evt_valid_i,
    input  logic [NB_CH*EVNT_WIDTH-1:0]        evt_data_i,
    output logic [NB_CH-1:0]                   evt_ready_o,
    output logic [BUFFER_WIDTH-1:0]            events_wt_o,
    input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
    output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
    output logic [FILL_BITS-1:0]               fill_o,
    output logic                               full_o,
    output logic [DROP_CNT_WIDTH-1:0]          drop_cnt_o
);

    localparam int IDX_BITS = $clog2(BUFFER_WIDTH);
    localparam int CH_W     = (NB_CH > 1) ? $clog2(NB_CH) : 1;
    localparam int SUM_W    = DROP_CNT_WIDTH + 1;

    logic [BUFFER_WIDTH-1:0]            rp_sync_q [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0]            rp_sync_d [SYNC_STAGES];
    logic [BUFFER_WIDTH-1:0]            wt_q, wt_d;
    logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_q, da_d;
    logic [IDX_BITS-1:0]                wr_idx_q, wr_idx_d;
    logic [DROP_CNT_WIDTH-1:0]          drop_cnt_q, drop_cnt_d;

    logic [BUFFER_WIDTH-1:0] occ;
    logic                    full;
    logic [CH_W-1:0]         gnt_idx;
    logic [NB_CH-1:0]        gnt_oh;
    logic                    gnt_vld;
    logic                    accept;
    logic [5:0]              n_drop;
    logic [SUM_W-1:0]        drop_sum;

    soc_event_rr_arb #(.NB_CH(NB_CH)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (evt_valid_i),
        .upd_i     (accept),
        .gnt_idx_o (gnt_idx),
        .gnt_oh_o  (gnt_oh),
        .gnt_vld_o (gnt_vld)
    );

    assign occ    = wt_q ^ rp_sync_q[SYNC_STAGES-1];
    assign full   = occ[wr_idx_q];
    assign accept = gnt_vld & ~full;

    always_comb begin
        rp_sync_d[0] = events_rp_i;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            rp_sync_d[s] = rp_sync_q[s-1];
        end

        wt_d     = wt_q;
        da_d     = da_q;
        wr_idx_d = wr_idx_q;
        if (accept) begin
            wt_d[wr_idx_q] = ~wt_q[wr_idx_q];
            da_d[int'(wr_idx_q)*EVNT_WIDTH +: EVNT_WIDTH] =
                evt_data_i[int'(gnt_idx)*EVNT_WIDTH +: EVNT_WIDTH];
            wr_idx_d = (wr_idx_q == IDX_BITS'(BUFFER_WIDTH - 1)) ? '0 : wr_idx_q + 1'b1;
        end

        // Every valid that is not the written one is lost in non-blocking mode.
        n_drop     = popcount(32'(evt_valid_i)) - {5'd0, accept};
        drop_sum   = {1'b0, drop_cnt_q} + SUM_W'(n_drop);
        drop_cnt_d = drop_cnt_q;
        if (BLOCKING == 0) begin
            drop_cnt_d = drop_sum[DROP_CNT_WIDTH] ? '1 : drop_sum[DROP_CNT_WIDTH-1:0];
        end

        if (BLOCKING == 0) begin
            evt_ready_o = '1;
        end else begin
            evt_ready_o = gnt_oh & {NB_CH{~full}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                rp_sync_q[s] <= '0;
            end
            wt_q       <= '0;
            da_q       <= '0;
            wr_idx_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rp_sync_q  <= rp_sync_d;
            wt_q       <= wt_d;
            da_q       <= da_d;
            wr_idx_q   <= wr_idx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign events_wt_o = wt_q;
    assign events_da_o = da_q;
    assign fill_o      = FILL_BITS'(popcount(32'(occ)));
    assign full_o      = full;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_soc_event_token_tx.sv
// Directed bench for soc_event_token_tx: one blocking and one dropping instance.
module tb_soc_event_token_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Blocking instance
    logic        rst_b;
    logic [3:0]  vld_b;
    logic [31:0] dat_b;
    logic [3:0]  rdy_b;
    logic [7:0]  wt_b;
    logic [7:0]  rp_b;
    logic [63:0] da_b;
    logic [3:0]  fill_b;
    logic        full_b;
    logic [15:0] drop_b;

    // Dropping instance
    logic        rst_n;
    logic [3:0]  vld_n;
    logic [31:0] dat_n;
    logic [3:0]  rdy_n;
    logic [7:0]  wt_n;
    logic [7:0]  rp_n;
    logic [63:0] da_n;
    logic [3:0]  fill_n;
    logic        full_n;
    logic [15:0] drop_n;

    int checks   = 0;
    int failures = 0;

    soc_event_token_tx #(.BLOCKING(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .evt_valid_i(vld_b), .evt_data_i(dat_b),
        .evt_ready_o(rdy_b), .events_wt_o(wt_b), .events_rp_i(rp_b),
        .events_da_o(da_b), .fill_o(fill_b), .full_o(full_b), .drop_cnt_o(drop_b)
    );

    soc_event_token_tx #(.BLOCKING(0)) dut_n (
        .clk_i(clk), .rst_i(rst_n), .evt_valid_i(vld_n), .evt_data_i(dat_n),
        .evt_ready_o(rdy_n), .events_wt_o(wt_n), .events_rp_i(rp_n),
        .events_da_o(da_n), .fill_o(fill_n), .full_o(full_n), .drop_cnt_o(drop_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b1; vld_b = '0; dat_b = '0; rp_b = '0;
        rst_n = 1'b1; vld_n = '0; dat_n = '0; rp_n = '0;
        tick(); tick();
        if (rdy_n !== 4'hF) begin failures++; $display("FAIL reset_ready_nb got=%h exp=f", rdy_n); end
        checks++;
        rst_b = 1'b0; rst_n = 1'b0;
        #1;
        if ({wt_b, fill_b, full_b, drop_b} !== '0) begin
            failures++; $display("FAIL reset_state wt=%h fill=%0d full=%b drop=%0d exp=0", wt_b, fill_b, full_b, drop_b);
        end
        checks++;
        if (da_b !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", da_b); end
        checks++;
    endtask

    task automatic test_single_write();
        vld_b = 4'b0100; dat_b = 32'h00A5_0000;
        #1;
        if (rdy_b !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", rdy_b); end
        checks++;
        tick();
        vld_b = '0;
        if (wt_b !== 8'h01 || da_b[7:0] !== 8'hA5 || fill_b !== 4'd1) begin
            failures++; $display("FAIL single_write wt=%h d0=%h fill=%0d exp wt=01 d0=a5 fill=1", wt_b, da_b[7:0], fill_b);
        end
        checks++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        vld_b = 4'hF; dat_b = 32'h1312_1110;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % 4);
            if (rdy_b !== exp_rdy) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, rdy_b, exp_rdy); end
            checks++;
            tick();
        end
        if (full_b !== 1'b1 || wt_b !== 8'hFF || rdy_b !== 4'h0 || fill_b !== 4'd8) begin
            failures++; $display("FAIL rr_full full=%b wt=%h rdy=%b fill=%0d exp 1 ff 0000 8", full_b, wt_b, rdy_b, fill_b);
        end
        checks++;
        if (da_b !== 64'h1312_1110_1312_1110) begin failures++; $display("FAIL rr_data got=%h exp=1312111013121110", da_b); end
        checks++;
        vld_b = '0;
    endtask

    task automatic test_free_wrap();
        rp_b = 8'h01;
        tick();
        if (fill_b !== 4'd8 || full_b !== 1'b1) begin failures++; $display("FAIL free_sync1 fill=%0d full=%b exp 8 1", fill_b, full_b); end
        checks++;
        tick();
        if (fill_b !== 4'd7 || full_b !== 1'b0) begin failures++; $display("FAIL free_sync2 fill=%0d full=%b exp 7 0", fill_b, full_b); end
        checks++;
        vld_b = 4'b0001; dat_b = 32'h0000_0077;
        #1;
        if (rdy_b !== 4'b0001) begin failures++; $display("FAIL wrap_ready got=%b exp=0001", rdy_b); end
        checks++;
        tick();
        vld_b = '0;
        if (wt_b !== 8'hFE || da_b[7:0] !== 8'h77 || fill_b !== 4'd8 || full_b !== 1'b1) begin
            failures++; $display("FAIL wrap_write wt=%h d0=%h fill=%0d full=%b exp fe 77 8 1", wt_b, da_b[7:0], fill_b, full_b);
        end
        checks++;
    endtask

    task automatic test_reset_mid_stream();
        rst_b = 1'b1; rp_b = '0; tick(); rst_b = 1'b0;
        vld_b = 4'b0010; dat_b = 32'h0000_4400;
        for (int i = 0; i < 5; i++) tick();
        vld_b = '0;
        if (wt_b !== 8'h1F) begin failures++; $display("FAIL mid_prefill wt=%h exp=1f", wt_b); end
        checks++;
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        if ({wt_b, fill_b, full_b, rdy_b} !== '0 || da_b !== 64'h0) begin
            failures++; $display("FAIL mid_reset wt=%h fill=%0d full=%b rdy=%b da=%h exp all 0", wt_b, fill_b, full_b, rdy_b, da_b);
        end
        checks++;
        vld_b = 4'b1001; dat_b = 32'hC300_005A;
        #1;
        if (rdy_b !== 4'b0001) begin failures++; $display("FAIL mid_grant got=%b exp=0001", rdy_b); end
        checks++;
        tick();
        vld_b = '0;
        if (wt_b !== 8'h01 || da_b[7:0] !== 8'h5A) begin
            failures++; $display("FAIL mid_write wt=%h d0=%h exp 01 5a", wt_b, da_b[7:0]);
        end
        checks++;
    endtask

    task automatic test_drop_full();
        rst_n = 1'b1; tick(); rst_n = 1'b0;
        vld_n = 4'b0100; dat_n = 32'h0020_0000;
        for (int i = 0; i < 8; i++) tick();
        if (full_n !== 1'b1 || drop_n !== 16'd0 || wt_n !== 8'hFF) begin
            failures++; $display("FAIL drop_prefill full=%b drop=%0d wt=%h exp 1 0 ff", full_n, drop_n, wt_n);
        end
        checks++;
        vld_n = 4'b0111;
        for (int i = 0; i < 5; i++) tick();
        if (drop_n !== 16'd15 || wt_n !== 8'hFF || rdy_n !== 4'hF) begin
            failures++; $display("FAIL drop_count drop=%0d wt=%h rdy=%b exp 15 ff 1111", drop_n, wt_n, rdy_n);
        end
        checks++;
    endtask

    task automatic test_drop_saturate();
        vld_n = 4'hF;
        for (int i = 0; i < 16379; i++) tick();
        if (drop_n !== 16'd65531) begin failures++; $display("FAIL drop_near_sat got=%0d exp=65531", drop_n); end
        checks++;
        tick();
        if (drop_n !== 16'hFFFF) begin failures++; $display("FAIL drop_sat got=%h exp=ffff", drop_n); end
        checks++;
        tick();
        vld_n = '0;
        if (drop_n !== 16'hFFFF) begin failures++; $display("FAIL drop_sat_hold got=%h exp=ffff", drop_n); end
        checks++;
    endtask

    task automatic test_contention_drop();
        rst_n = 1'b1; tick(); rst_n = 1'b0;
        if (drop_n !== 16'd0) begin failures++; $display("FAIL drop_reset got=%0d exp=0", drop_n); end
        checks++;
        vld_n = 4'b0011; dat_n = 32'h0000_2211;
        tick();
        vld_n = '0;
        if (drop_n !== 16'd1 || wt_n !== 8'h01 || fill_n !== 4'd1 || da_n[7:0] !== 8'h11) begin
            failures++; $display("FAIL contention drop=%0d wt=%h fill=%0d d0=%h exp 1 01 1 11", drop_n, wt_n, fill_n, da_n[7:0]);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_free_wrap();
        test_reset_mid_stream();
        test_drop_full();
        test_drop_saturate();
        test_contention_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_event_token_tx.md
Name: soc_event_token_tx

Overview:
- Parametrised SoC-side transmit half of the SoC-to-cluster event token buffer.
- Merges NB_CH event sources into one ring buffer of BUFFER_WIDTH slots.
- Publishes slots to the cluster domain using per-slot toggle tokens (events_wt_o) and accepts the cluster's toggle read pointer (events_rp_i), which it synchronises internally.
- Adds over the previous fixed single-source event port: a multi-channel round-robin merge, a selectable blocking or drop mode, a drop counter and a fill level.

Parameters:
- NB_CH, 4, number of event source channels (1..16).
- BUFFER_WIDTH, 8, number of ring slots; also the width of the token vectors (2..32, any value).
- EVNT_WIDTH, 8, event payload width.
- SYNC_STAGES, 2, flip-flop stages on events_rp_i (2..4).
- BLOCKING, 1, 1 = backpressure sources when full; 0 = always ready, drop when full and count.
- DROP_CNT_WIDTH, 16, width of the drop counter.

Ports:
- clk_i  in  1  SoC clock.
- rst_i  in  1  synchronous, active-high reset.
- evt_valid_i  in  NB_CH  per-channel event valid.
- evt_data_i  in  NB_CH*EVNT_WIDTH  per-channel payload; channel c occupies bits [c*EVNT_WIDTH +: EVNT_WIDTH].
- evt_ready_o  out  NB_CH  per-channel accept.
- events_wt_o  out  BUFFER_WIDTH  write toggle tokens, registered.
- events_rp_i  in  BUFFER_WIDTH  read toggle tokens from the cluster domain; asynchronous to clk_i.
- events_da_o  out  BUFFER_WIDTH*EVNT_WIDTH  slot data array, registered.
- fill_o  out  $clog2(BUFFER_WIDTH+1)  number of occupied slots.
- full_o  out  1  slot at the write index is occupied.
- drop_cnt_o  out  DROP_CNT_WIDTH  saturating count of dropped events (only counts when BLOCKING=0).

Behaviour:
- Reset (synchronous, active-high, rst_i):
  - events_wt_o, events_da_o, the write index, the round-robin pointer, all rp synchroniser flops and drop_cnt_o clear to 0.
  - fill_o=0, full_o=0.
  - evt_ready_o=all-ones when BLOCKING=0; otherwise per the rule below.
- Occupancy:
  - rp_s = events_rp_i after SYNC_STAGES flops.
  - occ = events_wt_o XOR rp_s.
  - fill_o = popcount(occ).
  - full_o = occ[wr_idx].
  - fill_o and full_o are combinational from registered state.
- Arbitration:
  - Round-robin across the asserted evt_valid_i bits, starting at rr_ptr.
  - The grant is to channel g.
  - After each accept, rr_ptr = (g+1) mod NB_CH.
  - rr_ptr is unchanged when nothing is accepted.
- Accept, BLOCKING=1:
  - evt_ready_o[g]=1 only when !full_o; all other ready bits are 0.
  - Handshake is valid&ready. Sources hold valid and data until accepted.
- Accept, BLOCKING=0:
  - evt_ready_o is all-ones.
  - The granted event is written if !full_o.
  - Every valid event not written in that cycle is counted as dropped. This covers the granted event when full, plus all non-granted valids.
  - drop_cnt_o increments by the number of dropped events and saturates at all-ones.
- Write, on an accept:
  - The data slot wr_idx takes the granted payload and events_wt_o[wr_idx] toggles, on the same edge.
  - wr_idx = (wr_idx+1) mod BUFFER_WIDTH; the wrap from BUFFER_WIDTH-1 to 0 also covers non-power-of-two depths.
  - Latency: accept at edge t means token and data are visible at the outputs after edge t.
  - Payload is stable from that edge until the slot is freed.
- Throughput: at most one event per cycle.
- Full: no write, tokens unchanged. Full clears SYNC_STAGES cycles after the receiver toggles events_rp_i[wr_idx].
- Simultaneous events:
  - A write and an rp_s change in the same cycle are independent per bit.
  - fill_o reflects both on the next cycle.
- Slot data is never modified while occ for that slot is 1.
- Reset mid-operation: all in-flight events are discarded. The receiver must be reset by the same global reset; no recovery handshake is defined.

Decomposition:
- Package soc_event_tx_pkg:
  - evt_t = logic [EVNT_WIDTH-1:0].
  - Function popcount.
  - Localparams FILL_W and IDX_W = $clog2(BUFFER_WIDTH).
- Sub-module soc_event_rr_arb:
  - Inputs: valid vector and an update strobe.
  - Outputs: grant index and a one-hot grant.
  - Holds the rr_ptr register.

Test Plan:
- Reset, then single write: rst_i high 2 cycles, then channel 2 valid, data 0xA5 for 1 cycle -> events_wt_o=0x01, slot 0 data=0xA5, fill_o=1, evt_ready_o[2]=1 in that cycle.
- Round-robin fairness: all 4 channels valid continuously, data 0x10+c, rp static 0 -> grants in order 0,1,2,3,0,1,2,3. After 8 cycles full_o=1, events_wt_o=0xFF, and all ready bits 0 (BLOCKING=1).
- Free and wrap: from full, toggle events_rp_i bit 0 -> full_o falls 2 cycles later. The next write goes to slot 0 and events_wt_o becomes 0xFE (bit 0 toggled back). fill_o goes 8 -> 7 -> 8.
- Drop mode (BLOCKING=0): buffer full, 3 channels valid for 5 cycles -> drop_cnt_o=15 and tokens unchanged. Preloading drop_cnt_o to 0xFFFE and dropping 3 more gives 0xFFFF (saturated).
- Non-full contention drops (BLOCKING=0): empty buffer, channels 0 and 1 valid in 1 cycle -> exactly one written, drop_cnt_o=1.
- Reset mid-stream: 5 events written, then rst_i pulse -> all outputs 0. The next accept is to channel 0 if valid, and goes to slot 0.
